// File: rtl/washing_machine.sv
// Washing machine cycle controller: sequences soak/wash/rinse/spin phases against an
// external phase timer, with lid pause/resume, cancel and a latched wash mode.
module washing_machine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cancel,
  input  logic       lid,
  input  logic       mode1,
  input  logic       mode2,
  input  logic       mode3,
  input  logic       timer_done,
  output logic [2:0] state,
  output logic [1:0] phase_sel,
  output logic       soak_en,
  output logic       wash_en,
  output logic       rinse_en,
  output logic       spin_en,
  output logic       timer_enable
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_SOAK   = 3'd2,
    S_WASH   = 3'd3,
    S_RINSE  = 3'd4,
    S_SPIN   = 3'd5,
    S_PAUSED = 3'd6,
    S_BAD    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    M_NONE   = 2'd0,
    M_QUICK  = 2'd1,
    M_NORMAL = 2'd2,
    M_HEAVY  = 2'd3
  } mode_e;

  state_e state_q, state_d;
  state_e saved_q, saved_d;
  mode_e  mode_q, mode_d;
  logic   rinse_q, rinse_d;
  logic   gap_q, gap_d;
  logic   anyMode;

  assign anyMode = mode1 | mode2 | mode3;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      mode_q  <= M_NONE;
      rinse_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      mode_q  <= mode_d;
      rinse_q <= rinse_d;
      gap_q   <= gap_d;
    end
  end

  // gap_q marks the single cycle between Heavy rinses where the timer is held off
  // so it restarts; a timer_done seen during that cycle is stale and ignored.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    mode_d  = mode_q;
    rinse_d = rinse_q;
    gap_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mode_d  = M_NONE;
        rinse_d = 1'b0;
        saved_d = S_IDLE;
        if (start && anyMode && !lid && !cancel) begin
          state_d = S_READY;
          if (mode3)      mode_d = M_HEAVY;
          else if (mode2) mode_d = M_NORMAL;
          else            mode_d = M_QUICK;
        end
      end
      S_READY: begin
        if (cancel)                 state_d = S_IDLE;
        else if (mode_q == M_QUICK) state_d = S_WASH;
        else                        state_d = S_SOAK;
      end
      S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (lid) begin
          state_d = S_PAUSED;
          saved_d = state_q;
        end else if (timer_done && !gap_q) begin
          case (state_q)
            S_SOAK: state_d = S_WASH;
            S_WASH: state_d = S_RINSE;
            S_RINSE: begin
              if (mode_q == M_HEAVY && !rinse_q) begin
                rinse_d = 1'b1;
                gap_d   = 1'b1;
              end else begin
                state_d = S_SPIN;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_PAUSED: begin
        if (cancel)    state_d = S_IDLE;
        else if (!lid) state_d = saved_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    state        = state_q;
    phase_sel    = 2'b00;
    soak_en      = 1'b0;
    wash_en      = 1'b0;
    rinse_en     = 1'b0;
    spin_en      = 1'b0;
    timer_enable = 1'b0;
    case (state_q)
      S_SOAK: begin
        soak_en      = 1'b1;
        timer_enable = !gap_q;
      end
      S_WASH: begin
        phase_sel    = 2'b01;
        wash_en      = 1'b1;
        timer_enable = !gap_q;
      end
      S_RINSE: begin
        phase_sel    = 2'b10;
        rinse_en     = 1'b1;
        timer_enable = !gap_q;
      end
      S_SPIN: begin
        phase_sel    = 2'b11;
        spin_en      = 1'b1;
        timer_enable = !gap_q;
      end
      S_PAUSED: begin
        case (saved_q)
          S_WASH:  phase_sel = 2'b01;
          S_RINSE: phase_sel = 2'b10;
          S_SPIN:  phase_sel = 2'b11;
          default: phase_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_washing_machine.sv
// Directed self-checking bench for washing_machine: walks each wash mode, pause,
// cancel, invalid starts and an asynchronous reset against hand-computed outputs.
module tb_washing_machine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cancel, lid, mode1, mode2, mode3, timer_done;
  logic [2:0] state;
  logic [1:0] phase_sel;
  logic       soak_en, wash_en, rinse_en, spin_en, timer_enable;

  int checks = 0;
  int passed = 0;

  washing_machine dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cancel(cancel),
    .lid(lid),
    .mode1(mode1),
    .mode2(mode2),
    .mode3(mode3),
    .timer_done(timer_done),
    .state(state),
    .phase_sel(phase_sel),
    .soak_en(soak_en),
    .wash_en(wash_en),
    .rinse_en(rinse_en),
    .spin_en(spin_en),
    .timer_enable(timer_enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseDone();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
  endtask

  // en is {soak_en, wash_en, rinse_en, spin_en}
  task automatic expectOut(input string tag, input logic [2:0] st, input logic [1:0] ps,
                           input logic [3:0] en, input logic te);
    logic [9:0] obs, exp;
    obs = {state, phase_sel, soak_en, wash_en, rinse_en, spin_en, timer_enable};
    exp = {st, ps, en, te};
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed st=%0d ps=%b en=%b te=%b, expected st=%0d ps=%b en=%b te=%b",
                tag, obs[9:7], obs[6:5], obs[4:1], obs[0], st, ps, en, te);
  endtask

  initial begin
    rst_n = 1'b1;
    {start, cancel, lid, mode1, mode2, mode3, timer_done} = '0;
    tick(); tick();
    expectOut("reset", 3'd0, 2'b00, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    tick();
    expectOut("post_reset_idle", 3'd0, 2'b00, 4'b0000, 1'b0);

    // Normal; mode inputs change after READY and must be ignored
    mode2 = 1'b1; start = 1'b1;
    tick();
    expectOut("normal_ready", 3'd1, 2'b00, 4'b0000, 1'b0);
    mode2 = 1'b0; mode1 = 1'b1;
    tick();
    expectOut("normal_soak", 3'd2, 2'b00, 4'b1000, 1'b1);
    tick(); tick(); tick();
    start = 1'b0;
    expectOut("normal_soak_hold", 3'd2, 2'b00, 4'b1000, 1'b1);
    pulseDone();
    expectOut("normal_wash", 3'd3, 2'b01, 4'b0100, 1'b1);
    tick(); tick();
    pulseDone();
    expectOut("normal_rinse", 3'd4, 2'b10, 4'b0010, 1'b1);
    tick();
    pulseDone();
    expectOut("normal_spin", 3'd5, 2'b11, 4'b0001, 1'b1);
    tick();
    pulseDone();
    expectOut("normal_done", 3'd0, 2'b00, 4'b0000, 1'b0);
    mode1 = 1'b0;
    tick();
    expectOut("idle_ignores_done", 3'd0, 2'b00, 4'b0000, 1'b0);

    // Quick
    mode1 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    expectOut("quick_ready", 3'd1, 2'b00, 4'b0000, 1'b0);
    tick();
    expectOut("quick_wash", 3'd3, 2'b01, 4'b0100, 1'b1);
    pulseDone();
    expectOut("quick_rinse", 3'd4, 2'b10, 4'b0010, 1'b1);
    pulseDone();
    expectOut("quick_spin", 3'd5, 2'b11, 4'b0001, 1'b1);
    pulseDone();
    expectOut("quick_done", 3'd0, 2'b00, 4'b0000, 1'b0);
    mode1 = 1'b0;

    // Heavy with two rinses and the one-cycle timer gap
    mode3 = 1'b1; mode1 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode3 = 1'b0; mode1 = 1'b0;
    expectOut("heavy_ready", 3'd1, 2'b00, 4'b0000, 1'b0);
    tick();
    expectOut("heavy_soak", 3'd2, 2'b00, 4'b1000, 1'b1);
    pulseDone();
    expectOut("heavy_wash", 3'd3, 2'b01, 4'b0100, 1'b1);
    pulseDone();
    expectOut("heavy_rinse1", 3'd4, 2'b10, 4'b0010, 1'b1);
    pulseDone();
    expectOut("heavy_rinse_gap", 3'd4, 2'b10, 4'b0010, 1'b0);
    tick();
    expectOut("heavy_rinse2", 3'd4, 2'b10, 4'b0010, 1'b1);
    pulseDone();
    expectOut("heavy_spin", 3'd5, 2'b11, 4'b0001, 1'b1);
    pulseDone();
    expectOut("heavy_done", 3'd0, 2'b00, 4'b0000, 1'b0);

    // Lid pause during WASH, lid/timer_done conflict, cancel in RINSE
    mode2 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode2 = 1'b0;
    tick();
    pulseDone();
    expectOut("lid_pre_wash", 3'd3, 2'b01, 4'b0100, 1'b1);
    lid = 1'b1;
    tick();
    expectOut("lid_paused", 3'd6, 2'b01, 4'b0000, 1'b0);
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    expectOut("paused_ignores_done", 3'd6, 2'b01, 4'b0000, 1'b0);
    lid = 1'b0;
    tick();
    expectOut("lid_resume", 3'd3, 2'b01, 4'b0100, 1'b1);
    lid = 1'b1; timer_done = 1'b1;
    tick();
    lid = 1'b0; timer_done = 1'b0;
    expectOut("lid_beats_done", 3'd6, 2'b01, 4'b0000, 1'b0);
    tick();
    expectOut("resume_after_conflict", 3'd3, 2'b01, 4'b0100, 1'b1);
    pulseDone();
    expectOut("cancel_pre_rinse", 3'd4, 2'b10, 4'b0010, 1'b1);
    cancel = 1'b1; lid = 1'b1; timer_done = 1'b1;
    tick();
    cancel = 1'b0; lid = 1'b0; timer_done = 1'b0;
    expectOut("cancel_rinse", 3'd0, 2'b00, 4'b0000, 1'b0);

    // Invalid starts
    lid = 1'b1; mode1 = 1'b1; start = 1'b1;
    tick();
    expectOut("start_lid_open", 3'd0, 2'b00, 4'b0000, 1'b0);
    lid = 1'b0; mode1 = 1'b0;
    tick();
    expectOut("start_no_mode", 3'd0, 2'b00, 4'b0000, 1'b0);
    mode1 = 1'b1; cancel = 1'b1;
    tick();
    expectOut("start_with_cancel", 3'd0, 2'b00, 4'b0000, 1'b0);
    start = 1'b0; mode1 = 1'b0; cancel = 1'b0;

    // Heavy: pause in second rinse keeps the rinse count, then async reset in SPIN
    mode3 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode3 = 1'b0;
    tick();
    pulseDone();
    pulseDone();
    pulseDone();
    tick();
    expectOut("heavy2_rinse2", 3'd4, 2'b10, 4'b0010, 1'b1);
    lid = 1'b1;
    tick();
    expectOut("heavy2_paused", 3'd6, 2'b10, 4'b0000, 1'b0);
    lid = 1'b0;
    tick();
    expectOut("heavy2_resume", 3'd4, 2'b10, 4'b0010, 1'b1);
    pulseDone();
    expectOut("heavy2_spin", 3'd5, 2'b11, 4'b0001, 1'b1);
    #2 rst_n = 1'b1;
    #1;
    expectOut("async_reset", 3'd0, 2'b00, 4'b0000, 1'b0);
    #1 rst_n = 1'b0;
    tick();
    expectOut("after_async_reset", 3'd0, 2'b00, 4'b0000, 1'b0);
    mode1 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode1 = 1'b0;
    expectOut("first_start_after_reset", 3'd1, 2'b00, 4'b0000, 1'b0);
    tick();
    expectOut("quick_after_reset", 3'd3, 2'b01, 4'b0100, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/washing_machine.md
WASHING_MACHINE -- requirements
Module: washing_machine

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-high (rst_n=1 resets immediately, independent of clk).
REQ-003 start  input  1  level request to begin a cycle; sampled only in IDLE.
REQ-004 cancel  input  1  abort request; level-sensitive.
REQ-005 lid  input  1  lid open when 1; closed when 0.
REQ-006 mode1, mode2, mode3  input  1 each  Quick, Normal and Heavy select; priority mode3 > mode2 > mode1.
REQ-007 timer_done  input  1  from external multi_phase_timer; phase-time-elapsed indication.
REQ-008 state  output  3  current state encoding (REQ-012).
REQ-009 phase_sel  output  2  phase code to timer: 00 soak, 01 wash, 10 rinse, 11 spin.
REQ-010 soak_en, wash_en, rinse_en, spin_en  output  1 each  one-hot phase activity; all 0 outside phase states.
REQ-011 timer_enable  output  1  timer run enable; 1 only in SOAK, WASH, RINSE and SPIN.

Function
REQ-012 State encoding: IDLE=0, READY=1, SOAK=2, WASH=3, RINSE=4, SPIN=5, PAUSED=6; code 7 recovers to IDLE on the next edge.
REQ-013 Outputs: Moore-decoded from registered state; no combinational path from inputs to outputs.
REQ-014 phase_sel per state: SOAK 00, WASH 01, RINSE 10, SPIN 11; IDLE/READY 00; PAUSED holds the code of the paused phase.
REQ-015 Start condition: IDLE -> READY when all hold:
  - start=1
  - at least one mode bit = 1
  - lid=0
  - cancel=0
  Otherwise the machine stays in IDLE.
REQ-016 Mode latch: the mode is captured on the IDLE->READY edge; mode inputs are ignored until the next return to IDLE.
REQ-017 READY lasts exactly one cycle, then enters the first phase: Quick -> WASH; Normal and Heavy -> SOAK.
REQ-018 Phase sequences (each advance on the edge where timer_done=1 in a phase state):
  - Quick: WASH, RINSE, SPIN, IDLE.
  - Normal: SOAK, WASH, RINSE, SPIN, IDLE.
  - Heavy: SOAK, WASH, RINSE, RINSE, SPIN, IDLE. The second RINSE is tracked by an internal rinse counter; state reads 4 for both rinses.
REQ-019 Between consecutive RINSE phases in Heavy mode, state is unchanged; timer_enable is driven 0 for exactly one cycle so the timer restarts.
REQ-020 timer_done is ignored in IDLE, READY and PAUSED.
REQ-021 start is ignored in every state except IDLE.
REQ-022 Lid open (lid=1) in any phase state -> PAUSED next edge:
  - the phase and rinse count are saved;
  - timer_enable=0 and all *_en=0 while PAUSED.
REQ-023 Resume: PAUSED with lid=0 -> the saved phase on the next edge, with the saved rinse count.
REQ-024 cancel=1 in any non-IDLE state -> IDLE next edge. Priority: cancel > lid > timer_done.
REQ-025 Edge conflicts:
  - Simultaneous lid=1 and timer_done=1 -> PAUSED; the timer_done is discarded.
  - Simultaneous cancel and anything -> IDLE.
REQ-026 Completion: after SPIN's timer_done, IDLE is entered and timer_enable=0 on that same edge.

Reset
REQ-027 While rst_n=1: state=IDLE(0), phase_sel=00, all *_en=0, timer_enable=0, latched mode cleared, rinse counter cleared, saved phase cleared.
REQ-028 Reset asserted mid-cycle forces IDLE immediately, with no wait for clk.
REQ-029 After reset is released, the first start is honoured per REQ-015.

Verification
REQ-030 Normal: mode2=1, start=1 for 5 cycles, timer_done pulsed 1 cycle after N cycles in each phase -> state 0,1,2,3,4,5,0; phase_sel 00,01,10,11; timer_enable=1 only in states 2-5.
REQ-031 Quick: mode1=1 -> state sequence 1,3,4,5,0; soak_en never asserted.
REQ-032 Heavy: mode3=1 -> states 1,2,3,4,4,5,0; a single-cycle timer_enable=0 gap occurs between the two rinses; all four *_en are exercised.
REQ-033 Lid: lid=1 during WASH -> state 6, timer_enable=0, wash_en=0, phase_sel=01; lid=0 -> state 3, timer_enable=1.
REQ-034 Cancel and invalid start:
  - cancel=1 during RINSE -> state 0 next edge.
  - start with lid=1 or no mode -> stays state 0.
REQ-035 Async reset: rst_n=1 pulse between edges during SPIN -> state=0 and all outputs 0 before the next rising clk.
